// File: rtl/pc_ctrl.sv
// pc_ctrl: program-counter controller for the fetch stage with stall,
// PC-relative branch, absolute jump, call/return and a circular
// return-address stack (RAS).
//   clk, rst (async, active high)
//   stall, ret_en, call_en, jump_en, ALU_zero : controls, in falling priority
//   branch_offs : signed PC-relative offset, jump_target : jump/call target
//   value : registered PC
//   ras_empty / ras_full : stack occupancy flags
//   ras_err : one-cycle pulse after a RAS overflow or underflow
// Optional macro PC_REDIRECT_CNT_EN adds redirect_cnt[15:0], a saturating
// count of cycles in which the PC was loaded by ret, call, jump or branch.
module pc_ctrl #(
  parameter int unsigned     PC_W      = 8,
  parameter int unsigned     OFFS_W    = 8,
  parameter int unsigned     RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              ALU_zero,
  input  logic [OFFS_W-1:0] branch_offs,
  input  logic              jump_en,
  input  logic              call_en,
  input  logic              ret_en,
  input  logic [PC_W-1:0]   jump_target,
  output logic [PC_W-1:0]   value,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_err
`ifdef PC_REDIRECT_CNT_EN
  ,
  output logic [15:0]       redirect_cnt
`endif
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  value_q, value_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             push;
  logic             redirect;
  logic [PC_W-1:0]  ras_q [RAS_DEPTH];

  logic [PC_W-1:0]  value_inc;
  logic [PC_W-1:0]  offs_ext;
  logic [PTR_W-1:0] top_idx;

  assign value_inc = value_q + PC_W'(1);
  assign offs_ext  = PC_W'($signed(branch_offs));
  // ptr_q addresses the next free slot; the newest entry sits one below.
  // Once full, the next free slot is also the oldest entry, so a push
  // overwrites it with no extra bookkeeping.
  assign top_idx   = ptr_q - PTR_W'(1);

  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));

  always_comb begin
    value_d  = value_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    push     = 1'b0;
    redirect = 1'b0;
    if (!stall) begin
      if (ret_en) begin
        redirect = 1'b1;
        if (!ras_empty) begin
          value_d = ras_q[top_idx];
          ptr_d   = top_idx;
          cnt_d   = cnt_q - CNT_W'(1);
        end else begin
          value_d = value_inc;
          err_d   = 1'b1;
        end
      end else if (call_en) begin
        redirect = 1'b1;
        push     = 1'b1;
        value_d  = jump_target;
        ptr_d    = ptr_q + PTR_W'(1);
        if (ras_full) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else if (jump_en) begin
        redirect = 1'b1;
        value_d  = jump_target;
      end else if (ALU_zero) begin
        redirect = 1'b1;
        value_d  = value_q + offs_ext;
      end else begin
        value_d = value_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= RESET_PC;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Stack contents are not reset; occupancy is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      ras_q[ptr_q] <= value_inc;
    end
  end

  assign value   = value_q;
  assign ras_err = err_q;

`ifdef PC_REDIRECT_CNT_EN
  logic [15:0] redir_q, redir_d;

  always_comb begin
    redir_d = redir_q;
    if (redirect && (redir_q != '1)) begin
      redir_d = redir_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redir_q <= '0;
    end else begin
      redir_q <= redir_d;
    end
  end

  assign redirect_cnt = redir_q;
`else
  logic unused_redirect;
  assign unused_redirect = redirect;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
module tb_pc_ctrl;

  localparam int unsigned PC_W      = 8;
  localparam int unsigned OFFS_W    = 8;
  localparam int unsigned RAS_DEPTH = 4;
  localparam logic [PC_W-1:0] RESET_PC = 8'h00;
  localparam int PC_MOD = 1 << PC_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              stall = 1'b0;
  logic              ALU_zero = 1'b0;
  logic [OFFS_W-1:0] branch_offs = '0;
  logic              jump_en = 1'b0;
  logic              call_en = 1'b0;
  logic              ret_en = 1'b0;
  logic [PC_W-1:0]   jump_target = '0;
  logic [PC_W-1:0]   value;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_err;
`ifdef PC_REDIRECT_CNT_EN
  logic [15:0]       redirect_cnt;
`endif

  pc_ctrl #(
    .PC_W(PC_W),
    .OFFS_W(OFFS_W),
    .RAS_DEPTH(RAS_DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .ALU_zero(ALU_zero),
    .branch_offs(branch_offs),
    .jump_en(jump_en),
    .call_en(call_en),
    .ret_en(ret_en),
    .jump_target(jump_target),
    .value(value),
    .ras_empty(ras_empty),
    .ras_full(ras_full),
    .ras_err(ras_err)
`ifdef PC_REDIRECT_CNT_EN
    ,
    .redirect_cnt(redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: PC as an integer, RAS as a queue of return addresses.
  int m_pc;
  int m_ras[$];
  bit m_err;
  int m_redir;

  function automatic void m_reset();
    m_pc = int'(RESET_PC);
    m_ras.delete();
    m_err = 1'b0;
    m_redir = 0;
  endfunction

  function automatic void m_step(input bit s, input bit r, input bit c, input bit j,
                                 input bit z, input int offs, input int tgt);
    m_err = 1'b0;
    if (s) return;
    if (r || c || j || z) begin
      if (m_redir < 65535) m_redir++;
    end
    if (r) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else begin
        m_pc = (m_pc + 1) % PC_MOD;
        m_err = 1'b1;
      end
    end else if (c) begin
      m_ras.push_back((m_pc + 1) % PC_MOD);
      if (m_ras.size() > RAS_DEPTH) begin
        void'(m_ras.pop_front());
        m_err = 1'b1;
      end
      m_pc = tgt;
    end else if (j) begin
      m_pc = tgt;
    end else if (z) begin
      m_pc = (((m_pc + offs) % PC_MOD) + PC_MOD) % PC_MOD;
    end else begin
      m_pc = (m_pc + 1) % PC_MOD;
    end
  endfunction

  // Drive one cycle of inputs, clock it, and advance the model.
  task automatic cyc(input bit s, input bit r, input bit c, input bit j,
                     input bit z, input int offs, input int tgt);
    stall = s;
    ret_en = r;
    call_en = c;
    jump_en = j;
    ALU_zero = z;
    branch_offs = OFFS_W'(offs);
    jump_target = PC_W'(tgt);
    @(posedge clk);
    #1;
    m_step(s, r, c, j, z, offs, tgt);
  endtask

  task automatic do_reset();
    stall = 0; ret_en = 0; call_en = 0; jump_en = 0; ALU_zero = 0;
    @(negedge clk);
    rst = 1'b1;
    #2;
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    m_reset();
    n_cmp++; if (value !== 8'h00) begin n_bad++; $display("FAIL reset_value: got %h expected 00", value); end
    n_cmp++; if (ras_empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b expected 1", ras_empty); end
    n_cmp++; if (ras_full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b expected 0", ras_full); end
    n_cmp++; if (ras_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", ras_err); end
    @(negedge clk);
    rst = 1'b0;
    for (int unsigned i = 1; i <= 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      n_cmp++; if (value !== PC_W'(i)) begin n_bad++; $display("FAIL idle_value%0d: got %h expected %h", i, value, PC_W'(i)); end
      n_cmp++; if (ras_empty !== 1'b1 || ras_err !== 1'b0) begin n_bad++; $display("FAIL idle_flags%0d: got empty=%b err=%b expected empty=1 err=0", i, ras_empty, ras_err); end
    end
  endtask

  task automatic test_wrap_branch();
    cyc(0, 0, 0, 1, 0, 0, 8'hFE);
    n_cmp++; if (value !== 8'hFE) begin n_bad++; $display("FAIL jump_fe: got %h expected fe", value); end
    cyc(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (value !== 8'hFF) begin n_bad++; $display("FAIL inc_ff: got %h expected ff", value); end
    cyc(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (value !== 8'h00) begin n_bad++; $display("FAIL wrap_00: got %h expected 00", value); end
    cyc(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (value !== 8'h01) begin n_bad++; $display("FAIL inc_01: got %h expected 01", value); end
    cyc(0, 0, 0, 0, 1, -3, 0);
    n_cmp++; if (value !== 8'hFE) begin n_bad++; $display("FAIL branch_back_wrap: got %h expected fe", value); end
    cyc(0, 0, 0, 0, 1, 5, 0);
    n_cmp++; if (value !== 8'h03) begin n_bad++; $display("FAIL branch_fwd_wrap: got %h expected 03", value); end
  endtask

  task automatic test_call_ret();
    cyc(0, 0, 0, 1, 0, 0, 10);
    cyc(0, 0, 1, 0, 0, 0, 40);
    n_cmp++; if (value !== 8'd40) begin n_bad++; $display("FAIL call_value: got %0d expected 40", value); end
    n_cmp++; if (ras_empty !== 1'b0 || ras_full !== 1'b0) begin n_bad++; $display("FAIL call_flags: got empty=%b full=%b expected 0 0", ras_empty, ras_full); end
    cyc(0, 1, 0, 0, 0, 0, 0);
    n_cmp++; if (value !== 8'd11) begin n_bad++; $display("FAIL ret_value: got %0d expected 11", value); end
    n_cmp++; if (ras_empty !== 1'b1 || ras_err !== 1'b0) begin n_bad++; $display("FAIL ret_flags: got empty=%b err=%b expected 1 0", ras_empty, ras_err); end
    // call together with ret on empty stack: ret wins (underflow), call dropped
    cyc(0, 1, 1, 1, 1, 9, 77);
    n_cmp++; if (value !== 8'd12 || ras_err !== 1'b1 || ras_empty !== 1'b1) begin n_bad++; $display("FAIL ret_beats_call: got v=%0d err=%b empty=%b expected 12 1 1", value, ras_err, ras_empty); end
  endtask

  task automatic test_ras_overflow();
    int exp_ret[4];
    exp_ret = '{51, 41, 31, 21};
    do_reset();
    for (int unsigned k = 0; k < 5; k++) begin
      cyc(0, 0, 1, 0, 0, 0, 20 + 10 * int'(k));
      n_cmp++; if (value !== PC_W'(20 + 10 * k)) begin n_bad++; $display("FAIL ovf_call%0d_value: got %0d expected %0d", k, value, 20 + 10 * k); end
      n_cmp++; if (ras_err !== (k == 4)) begin n_bad++; $display("FAIL ovf_call%0d_err: got %b expected %b", k, ras_err, k == 4); end
      n_cmp++; if (ras_full !== (k >= 3)) begin n_bad++; $display("FAIL ovf_call%0d_full: got %b expected %b", k, ras_full, k >= 3); end
    end
    for (int unsigned k = 0; k < 4; k++) begin
      cyc(0, 1, 0, 0, 0, 0, 0);
      n_cmp++; if (value !== PC_W'(exp_ret[k]) || ras_err !== 1'b0) begin n_bad++; $display("FAIL ovf_ret%0d: got v=%0d err=%b expected %0d 0", k, value, ras_err, exp_ret[k]); end
    end
    cyc(0, 1, 0, 0, 0, 0, 0);
    n_cmp++; if (value !== 8'd22 || ras_err !== 1'b1 || ras_empty !== 1'b1) begin n_bad++; $display("FAIL underflow: got v=%0d err=%b empty=%b expected 22 1 1", value, ras_err, ras_empty); end
    cyc(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (value !== 8'd23 || ras_err !== 1'b0) begin n_bad++; $display("FAIL err_one_cycle: got v=%0d err=%b expected 23 0", value, ras_err); end
  endtask

  task automatic test_stall();
    logic [PC_W-1:0] v0;
    cyc(0, 0, 1, 0, 0, 0, 100);
    v0 = value;
    cyc(1, 0, 1, 0, 1, 7, 200);
    n_cmp++; if (value !== v0 || value !== PC_W'(100)) begin n_bad++; $display("FAIL stall_value: got %0d expected 100", value); end
    n_cmp++; if (ras_empty !== 1'b0 || ras_err !== 1'b0) begin n_bad++; $display("FAIL stall_ras: got empty=%b err=%b expected 0 0", ras_empty, ras_err); end
    cyc(0, 1, 0, 0, 0, 0, 0);
    n_cmp++; if (value !== 8'd24 || ras_empty !== 1'b1) begin n_bad++; $display("FAIL stall_kept_ras: got v=%0d empty=%b expected 24 1", value, ras_empty); end
    cyc(0, 0, 1, 0, 0, 0, 90);
    stall = 1'b1;
    call_en = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    n_cmp++; if (value !== RESET_PC || ras_empty !== 1'b1 || ras_err !== 1'b0) begin n_bad++; $display("FAIL async_reset: got v=%0d empty=%b err=%b expected 0 1 0", value, ras_empty, ras_err); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      bit s, r, c, j, z;
      int offs, tgt;
      s = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 4) == 0);
      c = ($urandom_range(0, 3) == 0);
      j = ($urandom_range(0, 7) == 0);
      z = ($urandom_range(0, 3) == 0);
      offs = int'($urandom_range(0, 255)) - 128;
      tgt = int'($urandom_range(0, 255));
      cyc(s, r, c, j, z, offs, tgt);
      n_cmp++; if (value !== PC_W'(m_pc) || ras_err !== m_err || ras_empty !== (m_ras.size() == 0) || ras_full !== (m_ras.size() == RAS_DEPTH)) begin
        n_bad++;
        $display("FAIL rand%0d: got v=%0d err=%b empty=%b full=%b expected v=%0d err=%b depth=%0d", i, value, ras_err, ras_empty, ras_full, m_pc, m_err, m_ras.size());
      end
`ifdef PC_REDIRECT_CNT_EN
      n_cmp++; if (redirect_cnt !== 16'(m_redir)) begin n_bad++; $display("FAIL rand%0d_redir: got %0d expected %0d", i, redirect_cnt, m_redir); end
`endif
    end
  endtask

`ifdef PC_REDIRECT_CNT_EN
  task automatic test_redirect_cnt();
    do_reset();
    n_cmp++; if (redirect_cnt !== 16'd0) begin n_bad++; $display("FAIL redir_reset: got %0d expected 0", redirect_cnt); end
    cyc(0, 0, 0, 1, 0, 0, 30);
    cyc(0, 0, 0, 0, 1, 4, 0);
    cyc(1, 0, 0, 1, 0, 0, 50);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    n_cmp++; if (redirect_cnt !== 16'd3) begin n_bad++; $display("FAIL redir_mix: got %0d expected 3", redirect_cnt); end
    for (int i = 0; i < 65540; i++) cyc(0, 0, 0, 1, 0, 0, i % 256);
    n_cmp++; if (redirect_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL redir_sat: got %h expected ffff", redirect_cnt); end
    cyc(0, 0, 1, 0, 0, 0, 5);
    n_cmp++; if (redirect_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL redir_hold: got %h expected ffff", redirect_cnt); end
  endtask
`endif

  initial begin
    m_reset();
    test_reset();
    test_wrap_branch();
    test_call_ret();
    test_ras_overflow();
    test_stall();
    test_random();
`ifdef PC_REDIRECT_CNT_EN
    test_redirect_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
Parametrised program-counter controller for the MIPS core fetch stage. It generalises the basic PC with configurable PC and offset widths, stall, absolute jump, call/return and a circular return-address stack (RAS). The registered PC drives instruction-memory addressing; control inputs come from the decode/ALU stage.

Parameters:
PC_W, 8, PC register width in bits
OFFS_W, 8, branch offset width in bits (two's complement, OFFS_W <= PC_W)
RAS_DEPTH, 4, return-address stack entries (power of 2, >= 2)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
stall  input  1  hold PC and RAS this cycle
ALU_zero  input  1  branch-taken condition
branch_offs  input  OFFS_W  signed PC-relative branch offset
jump_en  input  1  absolute jump to jump_target
call_en  input  1  jump to jump_target and push return address
ret_en  input  1  pop RAS into PC
jump_target  input  PC_W  absolute target for jump/call
value  output  PC_W  current PC (registered)
ras_empty  output  1  RAS holds 0 entries (combinational from count)
ras_full  output  1  RAS holds RAS_DEPTH entries (combinational from count)
ras_err  output  1  one-cycle pulse on RAS overflow or underflow

Behaviour:
- Reset (async, any time, incl. mid-call): value=RESET_PC, RAS count=0, RAS pointer=0, ras_err=0, ras_empty=1, ras_full=0. Stored RAS entries need not be cleared.
- All updates on rising clk; value changes one cycle after the controlling inputs are sampled.
- Priority per cycle, highest first: stall > ret_en > call_en > jump_en > ALU_zero > increment.
- stall: value, RAS and count unchanged; ras_err=0. All other inputs ignored.
- ret_en, count>0: value <= top entry; pointer--, count--.
- ret_en, count==0 (underflow): value <= value+1; ras_err pulses 1 cycle; count stays 0.
- call_en: push value+1 (mod 2^PC_W); value <= jump_target. If count==RAS_DEPTH (overflow): push overwrites the oldest entry (circular), count stays RAS_DEPTH, ras_err pulses.
- jump_en: value <= jump_target; RAS untouched.
- ALU_zero: value <= value + sign_extend(branch_offs) to PC_W; signed addition, result mod 2^PC_W (wraps both directions).
- Otherwise: value <= value+1, wrapping from 2^PC_W-1 to 0.
- ras_err is registered; it is 0 in every cycle not following an overflow/underflow event.
- Lower-priority simultaneous requests are dropped silently (e.g. call_en with ret_en: only ret executes).

Optional Feature:
Macro PC_REDIRECT_CNT_EN. When defined: adds output redirect_cnt [15:0], counts cycles where value is loaded by ret (including underflow), call, jump or taken branch (not increment, not stall); saturates at 16'hFFFF; reset to 0 by rst. When undefined: port and counter absent, behaviour otherwise identical.

Test Plan:
- Reset then 3 idle cycles, PC_W=8 -> value 0,1,2,3; ras_empty=1; ras_err=0.
- value=8'hFE, two increments -> 8'hFF then 8'h00; ALU_zero=1, branch_offs=-3 at value=1 -> value=8'hFE.
- value=10, call_en, jump_target=40 -> value=40, count=1; next cycle ret_en -> value=11, ras_empty=1.
- RAS_DEPTH=4: five calls (from values 0, 20, 30, 40, 50, targets 20..60 in steps of 10) -> ras_full=1, ras_err pulse on 5th call only; four rets -> 51, 41, 31, 21; fifth ret -> underflow, value+1, ras_err pulse.
- stall=1 with call_en=1 and ALU_zero=1 -> value, count unchanged; stall+rst asserted mid-cycle -> immediate value=RESET_PC.
- PC_REDIRECT_CNT_EN defined: jump, taken branch, stall, increment, ret -> redirect_cnt=3; after 65540 jumps -> 16'hFFFF held.
